// File: rtl/gen_clk_monitor_pkg.sv
// Shared definitions for the generated-clock monitor.
// FSM encoding and counter sizing helpers.
package gen_clk_monitor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARM    = 2'd1,
    ST_TRACK  = 2'd2,
    ST_LOCKED = 2'd3
  } mon_state_e;

  function automatic int cnt_width(input int max_period);
    return $clog2(max_period + 1);
  endfunction

  // Lower tolerance bound clamped at zero.
  function automatic int tol_lo(input int exp_v, input int tol);
    return (exp_v > tol) ? exp_v - tol : 0;
  endfunction

endpackage

// File: rtl/gen_clk_monitor_edge_sync_detect.sv
// Synchroniser chain plus rise/fall pulse detector.
// STAGES=0 passes a same-domain registered source straight through.
module edge_sync_detect #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic s,
  output logic rise,
  output logic fall
);

  logic s_d_q;

  generate
    if (STAGES > 0) begin : g_sync
      logic [STAGES-1:0] sync_q;
      logic [STAGES-1:0] sync_d;

      always_comb begin
        sync_d    = sync_q << 1;
        sync_d[0] = d;
      end

      always_ff @(posedge clk) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= sync_d;
      end

      assign s = sync_q[STAGES-1];
    end else begin : g_pass
      assign s = d;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) s_d_q <= 1'b0;
    else        s_d_q <= s;
  end

  assign rise = s & ~s_d_q;
  assign fall = ~s & s_d_q;

endmodule

// File: rtl/gen_clk_monitor.sv
// Measures period/high time of a sampled divided clock.
// Tracks lock, flags out-of-tolerance periods and a dead clock.
module gen_clk_monitor
  import gen_clk_monitor_pkg::*;
#(
  parameter  int EXP_PERIOD  = 64,
  parameter  int EXP_HIGH    = 32,
  parameter  int TOL         = 0,
  parameter  int LOCK_CNT    = 4,
  parameter  int MAX_PERIOD  = 255,
  parameter  int SYNC_STAGES = 2,
  localparam int CNT_W       = cnt_width(MAX_PERIOD)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_gen_clk,
  output logic [CNT_W-1:0] o_period,
  output logic [CNT_W-1:0] o_high,
  output logic             o_period_valid,
  output logic             o_locked,
  output logic             o_err,
  output logic             o_timeout
);

  localparam logic [CNT_W:0] P_LO =
    (CNT_W+1)'(tol_lo(EXP_PERIOD, TOL));
  localparam logic [CNT_W:0] P_HI =
    (CNT_W+1)'(EXP_PERIOD + TOL);
  localparam logic [CNT_W:0] H_LO =
    (CNT_W+1)'(tol_lo(EXP_HIGH, TOL));
  localparam logic [CNT_W:0] H_HI =
    (CNT_W+1)'(EXP_HIGH + TOL);
  localparam logic [CNT_W-1:0] MAX_V  = CNT_W'(MAX_PERIOD);
  localparam logic [3:0]       LOCK_V = 4'(LOCK_CNT);

  logic s, rise, fall;
  logic good, per_sat, hi_sat;

  mon_state_e state_q, state_d;
  logic [3:0] match_q, match_d;

  logic [CNT_W-1:0] per_cnt_q, per_cnt_d;
  logic [CNT_W-1:0] hi_cnt_q, hi_cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic valid_q, valid_d;
  logic locked_q, locked_d;
  logic err_q, err_d;
  logic tmo_q, tmo_d;

  edge_sync_detect #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .d     (i_gen_clk),
    .s     (s),
    .rise  (rise),
    .fall  (fall)
  );

  assign per_sat = (per_cnt_q == MAX_V);
  assign hi_sat  = (hi_cnt_q == MAX_V);

  // One extra bit keeps the bounds safe when TOL exceeds EXP.
  assign good = ({1'b0, per_cnt_q} >= P_LO)
             && ({1'b0, per_cnt_q} <= P_HI)
             && ({1'b0, hi_cnt_q}  >= H_LO)
             && ({1'b0, hi_cnt_q}  <= H_HI);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      match_q <= '0;
    end else begin
      state_q <= state_d;
      match_q <= match_d;
    end
  end

  always_comb begin
    state_d = state_q;
    match_d = match_q;
    if (state_q == ST_IDLE) begin
      if (rise) state_d = ST_ARM;
    end else if (rise) begin
      if (good) begin
        unique case (1'b1)
          state_q == ST_ARM:    match_d = 4'd1;
          state_q == ST_LOCKED: match_d = match_q;
          default:              match_d = match_q + 4'd1;
        endcase
        state_d = (match_d >= LOCK_V) ? ST_LOCKED : ST_TRACK;
      end else begin
        match_d = '0;
        state_d = ST_TRACK;
      end
    end else if (per_sat) begin
      match_d = '0;
      state_d = ST_IDLE;
    end
  end

  always_comb begin
    valid_d  = rise && (state_q != ST_IDLE);
    err_d    = valid_d && !good;
    tmo_d    = (state_q != ST_IDLE) && !rise && per_sat;
    period_d = valid_d ? per_cnt_q : period_q;
    high_d   = valid_d ? hi_cnt_q  : high_q;
    locked_d = (state_d == ST_LOCKED);
  end

  always_comb begin
    per_cnt_d = per_cnt_q;
    hi_cnt_d  = hi_cnt_q;
    if (state_d == ST_IDLE) begin
      per_cnt_d = '0;
      hi_cnt_d  = '0;
    end else if (rise) begin
      per_cnt_d = CNT_W'(1);
      hi_cnt_d  = CNT_W'(1);
    end else begin
      if (!per_sat) per_cnt_d = per_cnt_q + CNT_W'(1);
      if (s && !fall && !hi_sat) hi_cnt_d = hi_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      per_cnt_q <= '0;
      hi_cnt_q  <= '0;
      period_q  <= '0;
      high_q    <= '0;
      valid_q   <= 1'b0;
      locked_q  <= 1'b0;
      err_q     <= 1'b0;
      tmo_q     <= 1'b0;
    end else begin
      per_cnt_q <= per_cnt_d;
      hi_cnt_q  <= hi_cnt_d;
      period_q  <= period_d;
      high_q    <= high_d;
      valid_q   <= valid_d;
      locked_q  <= locked_d;
      err_q     <= err_d;
      tmo_q     <= tmo_d;
    end
  end

  assign o_period       = period_q;
  assign o_high         = high_q;
  assign o_period_valid = valid_q;
  assign o_locked       = locked_q;
  assign o_err          = err_q;
  assign o_timeout      = tmo_q;

endmodule

// File: tb/tb_gen_clk_monitor.sv
// Bench for gen_clk_monitor: default div64 instance plus a fast
// unsynchronised div4 instance, checked against a timestamp model.
module tb_gen_clk_monitor;

  localparam int MAXE = 20000;

  typedef struct {
    int sync;
    int exp_p;
    int exp_h;
    int tol;
    int lock_cnt;
    int maxp;
    int last_rise;
    int last_fall;
    int streak;
    bit armed;
    int period;
    int high;
    bit vld;
    bit err;
    bit tmo;
    bit locked;
  } mdl_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, g_a, g_b;
  logic [7:0] a_period, a_high;
  logic a_vld, a_lock, a_err, a_tmo;
  logic [3:0] b_period, b_high;
  logic b_vld, b_lock, b_err, b_tmo;

  gen_clk_monitor dut_a (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_gen_clk      (g_a),
    .o_period       (a_period),
    .o_high         (a_high),
    .o_period_valid (a_vld),
    .o_locked       (a_lock),
    .o_err          (a_err),
    .o_timeout      (a_tmo)
  );

  gen_clk_monitor #(
    .EXP_PERIOD  (4),
    .EXP_HIGH    (2),
    .TOL         (1),
    .LOCK_CNT    (1),
    .MAX_PERIOD  (15),
    .SYNC_STAGES (0)
  ) dut_b (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_gen_clk      (g_b),
    .o_period       (b_period),
    .o_high         (b_high),
    .o_period_valid (b_vld),
    .o_locked       (b_lock),
    .o_err          (b_err),
    .o_timeout      (b_tmo)
  );

  bit   hist_a [MAXE];
  bit   hist_b [MAXE];
  int   last_rst = 0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  mdl_t ma, mb;
  int   b_mode = 1;
  int   b_pos = 0;
  int   b_lo = 2;
  int   b_hi = 2;

  // Level the monitor logic sees at edge k, given the sync delay.
  function automatic bit eff(input bit sel, input int k, input int sync);
    int src;
    src = k - sync;
    if (src < 0 || src <= last_rst) return 1'b0;
    return sel ? hist_b[src] : hist_a[src];
  endfunction

  function automatic void mstep(inout mdl_t m, input bit rst,
                                input int k, input bit cur, input bit prev);
    int p, h;
    bit good;
    m.vld = 0;
    m.err = 0;
    m.tmo = 0;
    if (rst) begin
      m.armed = 0;
      m.streak = 0;
      m.locked = 0;
      m.period = 0;
      m.high = 0;
      m.last_rise = 0;
      m.last_fall = -1;
      return;
    end
    if (!cur && prev) m.last_fall = k;
    if (cur && !prev) begin
      if (m.armed) begin
        p = k - m.last_rise;
        h = (m.last_fall > m.last_rise) ? m.last_fall - m.last_rise : p;
        if (p > m.maxp) p = m.maxp;
        if (h > m.maxp) h = m.maxp;
        good = (p >= m.exp_p - m.tol) && (p <= m.exp_p + m.tol)
            && (h >= m.exp_h - m.tol) && (h <= m.exp_h + m.tol);
        m.vld = 1;
        m.period = p;
        m.high = h;
        if (good) begin
          m.streak++;
          if (m.streak >= m.lock_cnt) m.locked = 1;
        end else begin
          m.err = 1;
          m.streak = 0;
          m.locked = 0;
        end
      end
      m.armed = 1;
      m.last_rise = k;
    end else if (m.armed && (k - m.last_rise >= m.maxp)) begin
      m.tmo = 1;
      m.armed = 0;
      m.streak = 0;
      m.locked = 0;
    end
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic step(input bit ga, input bit rst);
    bit gb;
    gb = 1'b0;
    if (b_mode != 0) begin
      gb = (b_pos >= b_lo);
      b_pos++;
      if (b_pos >= b_lo + b_hi) begin
        b_pos = 0;
        if (b_mode == 2) begin
          b_lo = $urandom_range(1, 3);
          b_hi = $urandom_range(1, 3);
        end else begin
          b_lo = 2;
          b_hi = 2;
        end
      end
    end
    g_a = ga;
    g_b = gb;
    rst_n = !rst;
    @(posedge clk);
    if (cyc >= MAXE - 1) begin
      $display("FAIL cycle_budget: got %0d limit %0d", cyc, MAXE);
      $fatal(1, "cycle budget exhausted");
    end
    hist_a[cyc] = ga;
    hist_b[cyc] = gb;
    if (rst) last_rst = cyc;
    mstep(ma, rst, cyc, eff(1'b0, cyc, ma.sync), eff(1'b0, cyc-1, ma.sync));
    mstep(mb, rst, cyc, eff(1'b1, cyc, mb.sync), eff(1'b1, cyc-1, mb.sync));
    cyc++;
    @(negedge clk);
    chk("a_period", 16'(a_period), 16'(ma.period));
    chk("a_high", 16'(a_high), 16'(ma.high));
    chk("a_valid", 16'(a_vld), 16'(ma.vld));
    chk("a_err", 16'(a_err), 16'(ma.err));
    chk("a_timeout", 16'(a_tmo), 16'(ma.tmo));
    chk("a_locked", 16'(a_lock), 16'(ma.locked));
    chk("a_err_tmo_excl", 16'(a_err & a_tmo), 16'd0);
    chk("b_period", 16'(b_period), 16'(mb.period));
    chk("b_high", 16'(b_high), 16'(mb.high));
    chk("b_valid", 16'(b_vld), 16'(mb.vld));
    chk("b_err", 16'(b_err), 16'(mb.err));
    chk("b_timeout", 16'(b_tmo), 16'(mb.tmo));
    chk("b_locked", 16'(b_lock), 16'(mb.locked));
  endtask

  task automatic per_a(input int lo, input int hi);
    repeat (lo) step(1'b0, 1'b0);
    repeat (hi) step(1'b1, 1'b0);
  endtask

  initial begin
    int t_seen;
    int nv;
    rst_n = 1'b0;
    g_a = 1'b0;
    g_b = 1'b0;
    ma = '{default: 0};
    ma.sync = 2; ma.exp_p = 64; ma.exp_h = 32;
    ma.tol = 0; ma.lock_cnt = 4; ma.maxp = 255;
    mb = '{default: 0};
    mb.sync = 0; mb.exp_p = 4; mb.exp_h = 2;
    mb.tol = 1; mb.lock_cnt = 1; mb.maxp = 15;
    @(negedge clk);

    repeat (3) step(1'b0, 1'b1);
    chk("reset_locked", 16'(a_lock), 16'd0);

    repeat (7) per_a(32, 32);
    chk("div64_locked", 16'(a_lock), 16'd1);
    chk("div64_period", 16'(a_period), 16'd64);
    chk("div64_high", 16'(a_high), 16'd32);
    chk("div4_locked", 16'(b_lock), 16'd1);

    repeat (12) per_a(2, 2);
    chk("fast_unlocked", 16'(a_lock), 16'd0);

    repeat (6) per_a(32, 32);
    chk("relock", 16'(a_lock), 16'd1);
    per_a(34, 32);
    chk("stretch_unlocked", 16'(a_lock), 16'd0);
    chk("stretch_period", 16'(a_period), 16'd66);
    repeat (5) per_a(32, 32);
    chk("stretch_relock", 16'(a_lock), 16'd1);

    t_seen = -1;
    for (int i = 0; i < 300; i++) begin
      step(1'b0, 1'b0);
      if (a_tmo === 1'b1 && t_seen < 0) t_seen = i;
    end
    chk("timeout_at", 16'(t_seen), 16'd225);
    chk("timeout_unlocked", 16'(a_lock), 16'd0);

    repeat (6) per_a(32, 32);
    chk("pre_reset_locked", 16'(a_lock), 16'd1);
    repeat (10) step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    chk("midrst_locked", 16'(a_lock), 16'd0);
    chk("midrst_period", 16'(a_period), 16'd0);
    nv = 0;
    repeat (22) step(1'b0, 1'b0);
    for (int i = 0; i < 32; i++) begin
      step(1'b1, 1'b0);
      if (a_vld === 1'b1) nv++;
    end
    chk("midrst_no_valid", 16'(nv), 16'd0);
    per_a(32, 32);
    chk("midrst_period2", 16'(a_period), 16'd64);

    b_mode = 2;
    repeat (25) per_a($urandom_range(31, 33), $urandom_range(31, 33));

    b_mode = 0;
    repeat (300) step(1'b1, 1'b0);
    chk("stuck_hi_unlocked", 16'(a_lock), 16'd0);
    b_mode = 1;
    repeat (20) step(1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
